// File: rtl/sccb_slave.sv
// SCCB target: START/STOP decode, 7-bit address match, 16-bit register pointer.
// Writes become register strobes; reads fetch through a one-cycle register port.
`timescale 1ns/1ps
module sccb_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int          MIN_PHASE  = 8
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oe,
  output logic [15:0] reg_addr_o,
  output logic [7:0]  reg_wdata_o,
  output logic        reg_we_o,
  output logic        reg_re_o,
  input  logic [7:0]  reg_rdata_i,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK, REG_H, REG_L,
    WR_DATA, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic scl_meta, scl_s, scl_d;
  logic sda_meta, sda_s, sda_d;
  logic [1:0] idle_cnt;
  logic armed_q;

  state_t state_q, state_d;
  state_t nxt_q, nxt_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic oe_q, oe_d;
  logic we_q, we_d;
  logic re_q, re_d;
  logic busy_q, busy_d;
  logic full_q, full_d;

  logic scl_rise, scl_fall;
  logic start_ev, stop_ev;
  logic [7:0] byte_in;

  // Two-flop synchronizers plus one delay flop for edge detection;
  // idle state (both lines high) is the reset value.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      scl_meta <= 1'b1;
      scl_s    <= 1'b1;
      scl_d    <= 1'b1;
      sda_meta <= 1'b1;
      sda_s    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_meta <= scl_i;
      scl_s    <= scl_meta;
      scl_d    <= scl_s;
      sda_meta <= sda_i;
      sda_s    <= sda_meta;
      sda_d    <= sda_s;
    end
  end

  // START is only honoured once the bus has been seen idle for 3 cycles.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      idle_cnt <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      if (scl_s && sda_s) begin
        if (idle_cnt != 2'd3) idle_cnt <= idle_cnt + 2'd1;
      end else begin
        idle_cnt <= 2'd0;
      end
      if (idle_cnt == 2'd3) armed_q <= 1'b1;
    end
  end

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_ev = armed_q & scl_s & sda_d & ~sda_s;
  assign stop_ev  = scl_s & ~sda_d & sda_s;
  assign byte_in  = {sh_q[6:0], sda_s};

  // Next-state and datapath decode; START/STOP override any data edge.
  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;
    full_d  = full_q;
    if (we_q) ptr_d = ptr_q + 16'd1;
    unique case (state_q)
      DEV_ADDR: begin
        if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              full_d = 1'b1;
              busy_d = 1'b1;
              nxt_d  = byte_in[0] ? RD_DATA : REG_H;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        if (scl_fall && full_q) begin
          state_d = ACK;
          oe_d    = 1'b1;
          full_d  = 1'b0;
        end
      end
      REG_H, REG_L, WR_DATA: begin
        if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            full_d = 1'b1;
            if (state_q == REG_H) begin
              ptr_d[15:8] = byte_in;
              nxt_d       = REG_L;
            end else if (state_q == REG_L) begin
              ptr_d[7:0] = byte_in;
              nxt_d      = WR_DATA;
            end else begin
              we_d    = 1'b1;
              wdata_d = byte_in;
              nxt_d   = WR_DATA;
            end
          end
        end
        if (scl_fall && full_q) begin
          state_d = ACK;
          oe_d    = 1'b1;
          full_d  = 1'b0;
        end
      end
      ACK: begin
        if (scl_fall) begin
          oe_d    = 1'b0;
          cnt_d   = 3'd0;
          state_d = nxt_q;
          if (nxt_q == RD_DATA) re_d = 1'b1;
        end
      end
      RD_DATA: begin
        if (re_q) begin
          sh_d = reg_rdata_i;
          oe_d = ~reg_rdata_i[7];
        end else if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
            state_d = RD_ACK;
          end else begin
            sh_d  = {sh_q[6:0], 1'b0};
            oe_d  = ~sh_q[6];
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      RD_ACK: begin
        if (scl_rise) begin
          if (!sda_s) begin
            ptr_d  = ptr_q + 16'd1;
            full_d = 1'b1;
          end else begin
            state_d = IGNORE;
          end
        end
        if (scl_fall && full_q) begin
          full_d  = 1'b0;
          re_d    = 1'b1;
          cnt_d   = 3'd0;
          state_d = RD_DATA;
        end
      end
      IDLE, IGNORE: ;
    endcase
    if (stop_ev) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      full_d  = 1'b0;
      we_d    = 1'b0;
      re_d    = 1'b0;
    end
    if (start_ev) begin
      state_d = DEV_ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      full_d  = 1'b0;
      we_d    = 1'b0;
      re_d    = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      nxt_q   <= IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= 8'd0;
      ptr_q   <= 16'd0;
      wdata_q <= 8'd0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
    end
  end

  assign sda_o       = 1'b0;
  assign sda_oe      = oe_q & ~srst_i;
  assign reg_addr_o  = ptr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = busy_q;

`ifndef SYNTHESIS
  logic [7:0] phase_cnt;

  // Cycles since the last synchronized SCL edge.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) phase_cnt <= '1;
    else if (scl_rise || scl_fall) phase_cnt <= '0;
    else if (phase_cnt != '1) phase_cnt <= phase_cnt + 8'd1;
  end

  // SCL phases shorter than MIN_PHASE are outside the tracked range.
  always @(posedge clk_i) begin
    if (!srst_i && (scl_rise || scl_fall))
      assert (phase_cnt >= 8'(MIN_PHASE - 1))
        else $error("scl phase shorter than MIN_PHASE");
  end
`endif

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: bus-level master tasks,
// strobe scoreboard and a small register read model.
`timescale 1ns/1ps
module tb_sccb_slave;

  localparam int Q = 10;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        srst_i;
  logic        scl;
  logic        sda_m;
  logic        sda_i;
  logic        sda_o;
  logic        sda_oe;
  logic [15:0] reg_addr_o;
  logic [7:0]  reg_wdata_o;
  logic        reg_we_o;
  logic        reg_re_o;
  logic [7:0]  reg_rdata_i = 8'd0;
  logic        busy_o;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic watch = 1'b0;
  logic seen_oe = 1'b0;
  logic seen_busy = 1'b0;

  always #5 clk = ~clk;

  assign sda_i = sda_m & ~sda_oe;

  sccb_slave dut (
    .clk_i       (clk),
    .srst_i      (srst_i),
    .scl_i       (scl),
    .sda_i       (sda_i),
    .sda_o       (sda_o),
    .sda_oe      (sda_oe),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_rdata_i (reg_rdata_i),
    .busy_o      (busy_o)
  );

  function automatic logic [7:0] rmodel(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h6C;
  endfunction

  always_ff @(posedge clk) reg_rdata_i <= rmodel(reg_addr_o);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (watch) begin
      if (sda_oe) seen_oe = 1'b1;
      if (busy_o) seen_busy = 1'b1;
    end
    if (reg_we_o || reg_re_o) begin
      int   n;
      exp_t e;
      n = exp_q.size();
      chk("strobe expected", n != 0, 1);
      chk("we/re exclusive", reg_we_o & reg_re_o, 0);
      if (n != 0) begin
        e = exp_q.pop_front();
        chk("strobe kind rd", reg_re_o, e.rd);
        chk("strobe addr", reg_addr_o, e.addr);
        if (!e.rd) chk("strobe wdata", reg_wdata_o, e.data);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; cyc(Q);
    scl = 1'b1;   cyc(Q);
    sda_m = 1'b0; cyc(Q);
    scl = 1'b0;   cyc(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; cyc(Q);
    scl = 1'b1;   cyc(Q);
    sda_m = 1'b1; cyc(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; cyc(Q);
      scl = 1'b1;   cyc(Q);
      scl = 1'b0;   cyc(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    sda_m = 1'b1; cyc(Q);
    scl = 1'b1;   cyc(Q / 2);
    ack = sda_i;  cyc(Q / 2);
    scl = 1'b0;   cyc(Q);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; cyc(Q);
      scl = 1'b1;   cyc(Q / 2);
      b[i] = sda_i; cyc(Q / 2);
      scl = 1'b0;   cyc(Q);
    end
    sda_m = mack ? 1'b0 : 1'b1; cyc(Q);
    scl = 1'b1; cyc(Q / 2);
    chk("released for master ack", sda_oe, 0);
    cyc(Q / 2);
    scl = 1'b0; cyc(Q);
    sda_m = 1'b1;
  endtask

  task automatic wr_acked(input string tag, input logic [7:0] b);
    logic a;
    write_byte(b, a);
    chk(tag, a, 0);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, " sda_oe"}, sda_oe, 0);
    chk({tag, " sda_o"}, sda_o, 0);
    chk({tag, " addr"}, reg_addr_o, 0);
    chk({tag, " wdata"}, reg_wdata_o, 0);
    chk({tag, " we"}, reg_we_o, 0);
    chk({tag, " re"}, reg_re_o, 0);
    chk({tag, " busy"}, busy_o, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    logic [7:0] b;
    srst_i = 1'b1;
    scl    = 1'b1;
    sda_m  = 1'b1;
    cyc(3);
    chk_outs_zero("reset");
    srst_i = 1'b0;
    cyc(Q);

    // single write 0x3008 <= 0x42
    bus_start();
    wr_acked("w1 dev ack", 8'h78);
    chk("w1 busy", busy_o, 1);
    wr_acked("w1 regh ack", 8'h30);
    wr_acked("w1 regl ack", 8'h08);
    exp_q.push_back('{rd: 1'b0, addr: 16'h3008, data: 8'h42});
    wr_acked("w1 data ack", 8'h42);
    bus_stop();
    chk("w1 busy after stop", busy_o, 0);
    chk("w1 drained", exp_q.size(), 0);

    // set pointer 0x300A then read one byte with NACK
    bus_start();
    wr_acked("p2 dev ack", 8'h78);
    wr_acked("p2 regh ack", 8'h30);
    wr_acked("p2 regl ack", 8'h0A);
    bus_stop();
    bus_start();
    exp_q.push_back('{rd: 1'b1, addr: 16'h300A, data: 8'h00});
    wr_acked("r2 dev ack", 8'h79);
    read_byte(1'b0, b);
    chk("r2 data", b, 8'h56);
    bus_stop();
    chk("r2 drained", exp_q.size(), 0);

    // wrong device address 0x21
    seen_oe = 1'b0;
    seen_busy = 1'b0;
    watch = 1'b1;
    bus_start();
    write_byte(8'h42, a);
    chk("wa dev nack", a, 1);
    write_byte(8'h30, a);
    write_byte(8'h00, a);
    write_byte(8'h11, a);
    bus_stop();
    watch = 1'b0;
    chk("wa never drove", seen_oe, 0);
    chk("wa never busy", seen_busy, 0);

    // burst write wrapping past 0xFFFF
    bus_start();
    wr_acked("bw dev ack", 8'h78);
    wr_acked("bw regh ack", 8'hFF);
    wr_acked("bw regl ack", 8'hFF);
    exp_q.push_back('{rd: 1'b0, addr: 16'hFFFF, data: 8'hAA});
    wr_acked("bw d0 ack", 8'hAA);
    exp_q.push_back('{rd: 1'b0, addr: 16'h0000, data: 8'hBB});
    wr_acked("bw d1 ack", 8'hBB);
    exp_q.push_back('{rd: 1'b0, addr: 16'h0001, data: 8'hCC});
    wr_acked("bw d2 ack", 8'hCC);
    bus_stop();
    chk("bw drained", exp_q.size(), 0);

    // aborted after REG_H, then full write 0x1234 <= 0x01
    bus_start();
    wr_acked("ab dev ack", 8'h78);
    wr_acked("ab regh ack", 8'h12);
    bus_stop();
    bus_start();
    wr_acked("ab2 dev ack", 8'h78);
    wr_acked("ab2 regh ack", 8'h12);
    wr_acked("ab2 regl ack", 8'h34);
    exp_q.push_back('{rd: 1'b0, addr: 16'h1234, data: 8'h01});
    wr_acked("ab2 data ack", 8'h01);
    bus_stop();
    chk("ab drained", exp_q.size(), 0);

    // two-byte burst read from 0xABCD
    bus_start();
    wr_acked("br dev ack", 8'h78);
    wr_acked("br regh ack", 8'hAB);
    wr_acked("br regl ack", 8'hCD);
    bus_stop();
    bus_start();
    exp_q.push_back('{rd: 1'b1, addr: 16'hABCD, data: 8'h00});
    exp_q.push_back('{rd: 1'b1, addr: 16'hABCE, data: 8'h00});
    wr_acked("br rdev ack", 8'h79);
    read_byte(1'b1, b);
    chk("br data0", b, rmodel(16'hABCD));
    read_byte(1'b0, b);
    chk("br data1", b, rmodel(16'hABCE));
    bus_stop();
    chk("br drained", exp_q.size(), 0);

    // async reset while the address ACK is driven
    bus_start();
    send_bits(8'h78);
    chk("rs ack driven", sda_oe, 1);
    @(negedge clk);
    srst_i = 1'b1;
    #1;
    chk("rs oe same cycle", sda_oe, 0);
    chk_outs_zero("rs");
    sda_m = 1'b1;
    scl = 1'b1;
    cyc(2);
    srst_i = 1'b0;
    cyc(Q);
    bus_start();
    wr_acked("rs2 dev ack", 8'h78);
    wr_acked("rs2 regh ack", 8'h00);
    wr_acked("rs2 regl ack", 8'h05);
    exp_q.push_back('{rd: 1'b0, addr: 16'h0005, data: 8'h77});
    wr_acked("rs2 data ack", 8'h77);
    bus_stop();
    chk("rs2 drained", exp_q.size(), 0);

    cyc(Q);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
